// File: rtl/csc_pkg.sv
// Shared constants and types for the RGB to YUV colour-space converter.
// Default coefficients are BT.601 full range with FRAC_BITS fractional bits.
package csc_pkg;

    localparam int FRAC_BITS = 8;
    localparam int NUM_COEF  = 9;

    typedef enum logic {
        FMT_422 = 1'b0,
        FMT_444 = 1'b1
    } fmt_e;

    typedef struct packed {
        logic [2:0] ppc;
        fmt_e       fmt;
        logic       avg;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{ppc: 3'd4, fmt: FMT_422, avg: 1'b0};

    // Order Yr,Yg,Yb,Ur,Ug,Ub,Vr,Vg,Vb
    localparam int DEFAULT_COEF [NUM_COEF] = '{77, 150, 29, -43, -84, 127, 127, -106, -21};

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

endpackage

// File: rtl/csc_pixel_mac.sv
// One pixel's 3x3 matrix multiply: products in stage 1, sums in stage 2,
// then combinational round / offset / clip to 8-bit Y, U, V.
module csc_pixel_mac
    import csc_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int COEF_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [9*COEF_WIDTH-1:0]      coef,
    input  logic [3*PIXEL_WIDTH-1:0]     rgb,
    output logic [7:0]                   y,
    output logic [7:0]                   u,
    output logic [7:0]                   v
);

    localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH + 1;
    localparam int SUM_W  = PIXEL_WIDTH + COEF_WIDTH + 3;
    localparam int SHIFT  = FRAC_BITS + PIXEL_WIDTH - 8;

    localparam logic signed [SUM_W-1:0] ROUND      = SUM_W'(1) <<< (SHIFT - 1);
    localparam logic signed [SUM_W-1:0] CHROMA_OFS = SUM_W'(128);
    localparam logic signed [SUM_W-1:0] ZERO       = '0;
    localparam logic signed [SUM_W-1:0] MAX8       = SUM_W'(255);

    logic [PIXEL_WIDTH-1:0]    chan   [3];
    logic signed [PROD_W-1:0]  prod_q [9];
    logic signed [SUM_W-1:0]   sum_q  [3];

    // chan[0..2] = R,G,B to line up with the Yr,Yg,Yb coefficient order
    assign chan[0] = rgb[2*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign chan[1] = rgb[PIXEL_WIDTH +: PIXEL_WIDTH];
    assign chan[2] = rgb[0 +: PIXEL_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= $signed({{(PROD_W - PIXEL_WIDTH){1'b0}}, chan[i % 3]})
                           * $signed({{(PROD_W - COEF_WIDTH){coef[i*COEF_WIDTH + COEF_WIDTH - 1]}},
                                      coef[i*COEF_WIDTH +: COEF_WIDTH]});
            end
            for (int c = 0; c < 3; c++) begin
                sum_q[c] <= SUM_W'(prod_q[3*c]) + SUM_W'(prod_q[3*c + 1]) + SUM_W'(prod_q[3*c + 2]);
            end
        end
    end

    function automatic logic [7:0] to_byte(input logic signed [SUM_W-1:0] sum, input logic chroma);
        logic signed [SUM_W-1:0] t;
        t = (sum + ROUND) >>> SHIFT;
        if (chroma) t = t + CHROMA_OFS;
        if (t < ZERO)      return 8'd0;
        else if (t > MAX8) return 8'd255;
        else               return t[7:0];
    endfunction

    assign y = to_byte(sum_q[0], 1'b0);
    assign u = to_byte(sum_q[1], 1'b1);
    assign v = to_byte(sum_q[2], 1'b1);

endmodule

// File: rtl/rgb_to_yuv_csc.sv
// Multi-pixel RGB to YUV444 / YUV422 converter with a 3-stage pipeline.
// Handshake: a beat moves when valid and ready are both high on a rising edge; the whole pipeline advances only when !valid_o || ready_i, which is also ready_o.
module rgb_to_yuv_csc
    import csc_pkg::*;
#(
    parameter int MAX_PPC     = 4,
    parameter int PIXEL_WIDTH = 10,
    parameter int COEF_WIDTH  = 10
) (
    input  logic                               pixel_clk_i,
    input  logic                               reset_i,
    input  logic [2:0]                         pixel_per_clk_reg_i,
    input  logic                               out_format_reg_i,
    input  logic                               chroma_avg_reg_i,
    input  logic [9*COEF_WIDTH-1:0]            coef_reg_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [3*PIXEL_WIDTH*MAX_PPC-1:0]   rgb_data_i,
    input  logic                               line_end_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [24*MAX_PPC-1:0]              yuv_data_o,
    output logic [3*MAX_PPC-1:0]               yuv_byte_valid_o,
    output logic                               line_end_o
);

    localparam int LANES = 3 * MAX_PPC;

    logic               en;
    logic               accept;
    logic               line_start_q;
    cfg_t               cfg_q;
    cfg_t               cfg_in;
    cfg_t               s1_cfg;
    cfg_t               s2_cfg;
    logic               s1_valid;
    logic               s1_last;
    logic               s2_valid;
    logic               s2_last;
    logic               phase_q;
    logic [7:0]         stored_v_q;
    logic [7:0]         pix_y [MAX_PPC];
    logic [7:0]         pix_u [MAX_PPC];
    logic [7:0]         pix_v [MAX_PPC];
    logic [8*LANES-1:0] data_d;
    logic [LANES-1:0]   bv_d;
    int                 n_pix;
    int                 n_lanes;

    assign en      = !valid_o || ready_i;
    assign ready_o = en;
    assign accept  = valid_i && en;

    // Configuration is taken from the ports only on the first beat of a line
    always_comb begin
        cfg_in = cfg_q;
        if (line_start_q) begin
            cfg_in.ppc = pixel_per_clk_reg_i;
            cfg_in.fmt = fmt_e'(out_format_reg_i);
            cfg_in.avg = chroma_avg_reg_i;
        end
    end

    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            line_start_q <= 1'b1;
            cfg_q        <= CFG_RESET;
        end else if (accept) begin
            line_start_q <= line_end_i;
            cfg_q        <= cfg_in;
        end
    end

    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cfg   <= CFG_RESET;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_cfg   <= CFG_RESET;
        end else if (en) begin
            s1_valid <= valid_i;
            s1_last  <= valid_i && line_end_i;
            s1_cfg   <= cfg_in;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_cfg   <= s1_cfg;
        end
    end

    for (genvar k = 0; k < MAX_PPC; k++) begin : g_pix
        csc_pixel_mac #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH)
        ) u_mac (
            .clk  (pixel_clk_i),
            .en   (en),
            .coef (coef_reg_i),
            .rgb  (rgb_data_i[k*3*PIXEL_WIDTH +: 3*PIXEL_WIDTH]),
            .y    (pix_y[k]),
            .u    (pix_u[k]),
            .v    (pix_v[k])
        );
    end

    always_comb begin
        data_d  = '0;
        bv_d    = '0;
        n_pix   = int'(s2_cfg.ppc);
        n_lanes = 0;
        if (s2_cfg.fmt == FMT_444) begin
            for (int k = 0; k < MAX_PPC; k++) begin
                if (k < n_pix) begin
                    data_d[24*k +: 8]      = pix_y[k];
                    data_d[24*k + 8 +: 8]  = pix_u[k];
                    data_d[24*k + 16 +: 8] = pix_v[k];
                end
            end
            n_lanes = 3 * n_pix;
        end else if (n_pix == 1) begin
            // Single-pixel 422: odd beats reuse V of the preceding even pixel
            data_d[7:0]  = pix_y[0];
            data_d[15:8] = phase_q ? stored_v_q : pix_u[0];
            n_lanes      = 2;
        end else begin
            for (int j = 0; j < MAX_PPC / 2; j++) begin
                if (2*j < n_pix) begin
                    data_d[32*j +: 8]      = pix_y[2*j];
                    data_d[32*j + 8 +: 8]  = s2_cfg.avg ? avg8(pix_u[2*j], pix_u[2*j + 1]) : pix_u[2*j];
                    data_d[32*j + 16 +: 8] = pix_y[2*j + 1];
                    data_d[32*j + 24 +: 8] = s2_cfg.avg ? avg8(pix_v[2*j], pix_v[2*j + 1]) : pix_v[2*j];
                end
            end
            n_lanes = 2 * n_pix;
        end
        for (int i = 0; i < LANES; i++) begin
            bv_d[i] = (i < n_lanes);
        end
    end

    // Every beat loaded into the output stage leaves in order, so tracking the
    // phase at load time matches toggling it on the output transfer.
    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            phase_q    <= 1'b0;
            stored_v_q <= '0;
        end else if (en && s2_valid) begin
            phase_q <= s2_last ? 1'b0 : !phase_q;
            if (!phase_q) stored_v_q <= pix_v[0];
        end
    end

    always_ff @(posedge pixel_clk_i) begin
        if (reset_i) begin
            valid_o          <= 1'b0;
            line_end_o       <= 1'b0;
            yuv_data_o       <= '0;
            yuv_byte_valid_o <= '0;
        end else if (en) begin
            valid_o          <= s2_valid;
            line_end_o       <= s2_last;
            yuv_data_o       <= s2_valid ? data_d : '0;
            yuv_byte_valid_o <= s2_valid ? bv_d : '0;
        end
    end

endmodule
